// File: rtl/freq_counter_pkg.sv
// Shared types for the multi-channel frequency counter: widths, FSM encodings,
// window-length and frequency-scaling helpers.
package freq_counter_pkg;

  localparam int CNT_W  = 32;
  localparam int CHAN_W = 4;
  localparam int GS_W   = 3;
  localparam int SNAP_N = 2 ** CHAN_W;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [CHAN_W-1:0] chan_t;
  typedef logic [GS_W-1:0]   gs_t;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} gate_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_t;

  typedef struct packed {
    logic ovf;
    cnt_t freq;
  } result_t;

  // Countdown preload for a window of (clock_freq >> gs) cycles.
  function automatic cnt_t win_load(input int unsigned clock_freq, input gs_t gs);
    int unsigned len;
    len = clock_freq >> gs;
    return (len == 0) ? '0 : cnt_t'(len - 1);
  endfunction

  // count << sh, saturating to all-ones when any shifted-out bit is set.
  function automatic result_t scale_freq(input cnt_t count, input logic cnt_ovf,
                                         input int unsigned sh);
    logic [2*CNT_W-1:0] wide;
    result_t            r;
    if (sh >= CNT_W) begin
      r.ovf  = cnt_ovf | (count != '0);
      r.freq = r.ovf ? '1 : '0;
    end else begin
      wide   = {{CNT_W{1'b0}}, count} << sh;
      r.ovf  = cnt_ovf | (|wide[2*CNT_W-1:CNT_W]);
      r.freq = r.ovf ? '1 : wide[CNT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_freq_counter_if.sv
// Result stream: one beat per channel, valid/ready handshake.
interface multi_freq_counter_if;
  import freq_counter_pkg::*;

  logic  m_valid;
  logic  m_ready;
  chan_t m_chan;
  cnt_t  m_freq;
  logic  m_ovf;
  logic  m_last;

  modport master (output m_valid, m_chan, m_freq, m_ovf, m_last, input m_ready);
  modport slave  (input m_valid, m_chan, m_freq, m_ovf, m_last, output m_ready);

endinterface

// File: rtl/edge_sync_counter.sv
// Per-channel synchroniser, rising-edge detect and saturating edge counter.
// Latency: SYNC_STAGES+1 cycles from pin to count; closing value latched on cap.
// Backpressure: none; counts every detected edge while en is high.
module edge_sync_counter
  import freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  input  logic en,
  input  logic clr,
  input  logic cap,
  output cnt_t fin_cnt,
  output logic fin_ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  cnt_t                   cnt_q;
  logic                   ovf_q;
  cnt_t                   cnt_inc;
  logic                   ovf_inc;

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // cnt_inc includes this cycle's edge so the closing cycle lands in fin_cnt.
  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (en && rise) begin
      if (cnt_q == '1) ovf_inc = 1'b1;
      else             cnt_inc = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fin_cnt <= '0;
      fin_ovf <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (cap) begin
        fin_cnt <= cnt_inc;
        fin_ovf <= ovf_inc;
      end
      if (clr) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_inc;
        ovf_q <= ovf_inc;
      end
    end
  end

endmodule

// File: rtl/multi_freq_counter.sv
// Gated multi-channel frequency counter streaming one result beat per channel.
// Latency: results snapshot 1 cycle after window end, first beat valid next cycle.
// Backpressure: m_* held until m_ready; a window ending mid-readout is dropped (missed).
module multi_freq_counter
  import freq_counter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 200000000,
  parameter int          NCH         = 4,
  parameter int          SYNC_STAGES = 3,
  parameter int          DIV_SHIFT   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       inp_sig,
  input  logic                 start,
  input  logic                 continuous,
  input  gs_t                  gate_shift,
  output logic                 busy,
  output logic                 missed,
  multi_freq_counter_if.master m_bus
);

  localparam int unsigned DIV_SH = DIV_SHIFT;

  gate_state_t gate_q, gate_d;
  cnt_t        down_q;
  gs_t         win_gs_q;
  gs_t         cap_gs_q;
  logic        cap_d_q;
  logic        win_start;
  logic        win_end;

  always_comb begin
    gate_d    = gate_q;
    win_start = 1'b0;
    win_end   = 1'b0;
    case (gate_q)
      IDLE: begin
        if (start || continuous) begin
          gate_d    = MEASURE;
          win_start = 1'b1;
        end
      end
      MEASURE: begin
        if (down_q == '0) begin
          win_end = 1'b1;
          if (continuous) win_start = 1'b1;
          else            gate_d    = IDLE;
        end
      end
      default: gate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q   <= IDLE;
      down_q   <= '0;
      win_gs_q <= '0;
      cap_gs_q <= '0;
      cap_d_q  <= 1'b0;
    end else begin
      gate_q <= gate_d;
      if (win_start) begin
        down_q   <= win_load(CLOCK_FREQ, gate_shift);
        win_gs_q <= gate_shift;
      end else if (gate_q == MEASURE) begin
        down_q <= down_q - 1'b1;
      end
      if (win_end) cap_gs_q <= win_gs_q;
      cap_d_q <= win_end;
    end
  end

  assign busy = (gate_q == MEASURE);

  cnt_t    fin_cnt [NCH];
  logic    fin_ovf [NCH];
  result_t res     [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    edge_sync_counter #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .sig     (inp_sig[g]),
      .en      (busy),
      .clr     (win_start | win_end),
      .cap     (win_end),
      .fin_cnt (fin_cnt[g]),
      .fin_ovf (fin_ovf[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      res[i] = scale_freq(fin_cnt[i], fin_ovf[i], DIV_SH + 32'(cap_gs_q));
    end
  end

  rd_state_t rd_q, rd_d;
  chan_t     idx_q;
  result_t   snap_q [SNAP_N];
  logic      snap_take;
  logic      beat_done;
  logic      last_beat;
  logic      missed_q;

  always_comb begin
    rd_d      = rd_q;
    snap_take = 1'b0;
    beat_done = (rd_q == RD_SEND) && m_bus.m_ready;
    last_beat = (idx_q == chan_t'(NCH - 1));
    case (rd_q)
      RD_IDLE: begin
        if (cap_d_q) begin
          rd_d      = RD_SEND;
          snap_take = 1'b1;
        end
      end
      RD_SEND: begin
        if (beat_done && last_beat) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= RD_IDLE;
      idx_q    <= '0;
      missed_q <= 1'b0;
      for (int i = 0; i < SNAP_N; i++) snap_q[i] <= '0;
    end else begin
      rd_q <= rd_d;
      // A window closing while the previous one is still streaming is dropped.
      if (cap_d_q && (rd_q != RD_IDLE)) missed_q <= 1'b1;
      if (snap_take) begin
        idx_q <= '0;
        for (int i = 0; i < NCH; i++) snap_q[i] <= res[i];
      end else if (beat_done) begin
        idx_q <= last_beat ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign missed        = missed_q;
  assign m_bus.m_valid = (rd_q == RD_SEND);
  assign m_bus.m_chan  = m_bus.m_valid ? idx_q : '0;
  assign m_bus.m_freq  = m_bus.m_valid ? snap_q[idx_q].freq : '0;
  assign m_bus.m_ovf   = m_bus.m_valid & snap_q[idx_q].ovf;
  assign m_bus.m_last  = m_bus.m_valid & last_beat;

endmodule

// File: tb/tb_multi_freq_counter.sv
// Directed bench for multi_freq_counter: two instances (DIV_SHIFT 0 and 26).
module tb_multi_freq_counter;
  import freq_counter_pkg::*;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] inp_sig;
  logic           start, continuous, start2, cont2;
  gs_t            gate_shift;
  logic           busy, missed, busy2, missed2;

  int tests_run    = 0;
  int tests_failed = 0;
  int halfp [NCH];

  multi_freq_counter_if bus ();
  multi_freq_counter_if bus2 ();

  always #5 clk = ~clk;

  multi_freq_counter #(.CLOCK_FREQ(1000), .NCH(NCH), .SYNC_STAGES(3), .DIV_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .inp_sig(inp_sig), .start(start), .continuous(continuous),
    .gate_shift(gate_shift), .busy(busy), .missed(missed), .m_bus(bus));

  multi_freq_counter #(.CLOCK_FREQ(1000), .NCH(NCH), .SYNC_STAGES(3), .DIV_SHIFT(26)) u_dut2 (
    .clk(clk), .reset(reset), .inp_sig(inp_sig), .start(start2), .continuous(cont2),
    .gate_shift(gate_shift), .busy(busy2), .missed(missed2), .m_bus(bus2));

  // Square-wave sources: channel i toggles every halfp[i] cycles, 0 = held low.
  initial begin
    int gcnt [NCH];
    inp_sig = '0;
    for (int i = 0; i < NCH; i++) gcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (halfp[i] == 0) begin
          inp_sig[i] = 1'b0;
          gcnt[i]    = 0;
        end else begin
          gcnt[i]++;
          if (gcnt[i] >= halfp[i]) begin
            inp_sig[i] = ~inp_sig[i];
            gcnt[i]    = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input bit second);
    @(negedge clk);
    if (second) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input bit second, output int len);
    len = 0;
    while (((second ? busy2 : busy) === 1'b1) && len < 5000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic get_beat(input bit second, output logic [38:0] beat);
    bit ok;
    ok   = 1'b0;
    beat = 'x;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (!second && bus.m_valid === 1'b1) begin
        ok   = 1'b1;
        beat = {1'b1, bus.m_chan, bus.m_freq, bus.m_ovf, bus.m_last};
      end else if (second && bus2.m_valid === 1'b1) begin
        ok   = 1'b1;
        beat = {1'b1, bus2.m_chan, bus2.m_freq, bus2.m_ovf, bus2.m_last};
      end
    end
    if (!ok) beat = '0;
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    repeat (3) @(negedge clk);
    obs = {busy, missed, bus.m_valid, bus.m_last, bus.m_chan, bus.m_freq, bus.m_ovf};
    tests_run++;
    if (obs !== 42'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    obs = {busy2, missed2, bus2.m_valid, bus2.m_last, bus2.m_chan, bus2.m_freq, bus2.m_ovf};
    tests_run++;
    if (obs !== 42'd0) begin
      tests_failed++; $display("FAIL reset_outputs2: got %h want 0", obs);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_window();
    int len;
    logic [38:0] beat, exp_b;
    pulse_start(1'b0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL single_busy_rise: got %b want 1", busy);
    end
    wait_idle(1'b0, len);
    tests_run++;
    if (len != 1000) begin
      tests_failed++; $display("FAIL single_window_len: got %0d want 1000", len);
    end
    for (int i = 0; i < NCH; i++) begin
      get_beat(1'b0, beat);
      exp_b = {1'b1, 4'(i), (i == 0) ? 32'd100 : 32'd0, 1'b0, (i == NCH - 1)};
      tests_run++;
      if (beat !== exp_b) begin
        tests_failed++; $display("FAIL single_beat%0d: got %h want %h", i, beat, exp_b);
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, bus.m_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL single_idle_after: got %b want 00", {busy, bus.m_valid});
    end
  endtask

  task automatic test_gate_shift();
    int len;
    logic [38:0] beat, exp_b;
    gate_shift = 3'd1;
    pulse_start(1'b0);
    gate_shift = 3'd3;
    wait_idle(1'b0, len);
    tests_run++;
    if (len != 500) begin
      tests_failed++; $display("FAIL gs1_window_len: got %0d want 500", len);
    end
    for (int i = 0; i < NCH; i++) begin
      get_beat(1'b0, beat);
      exp_b = {1'b1, 4'(i), (i == 0) ? 32'd100 : 32'd0, 1'b0, (i == NCH - 1)};
      tests_run++;
      if (beat !== exp_b) begin
        tests_failed++; $display("FAIL gs1_beat%0d: got %h want %h", i, beat, exp_b);
      end
    end
    gate_shift = 3'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overflow();
    int len;
    logic [38:0] beat, exp_b;
    pulse_start(1'b1);
    wait_idle(1'b1, len);
    tests_run++;
    if (len != 1000) begin
      tests_failed++; $display("FAIL ovf_window_len: got %0d want 1000", len);
    end
    for (int i = 0; i < NCH; i++) begin
      get_beat(1'b1, beat);
      exp_b = {1'b1, 4'(i), (i == 0) ? 32'hFFFF_FFFF : 32'd0, (i == 0), (i == NCH - 1)};
      tests_run++;
      if (beat !== exp_b) begin
        tests_failed++; $display("FAIL ovf_beat%0d: got %h want %h", i, beat, exp_b);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int len;
    logic [38:0] beat, exp_b;
    pulse_start(1'b0);
    len = 0;
    while (busy === 1'b1 && len < 5000) begin
      start = (len == 300);
      len++;
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (len != 1000) begin
      tests_failed++; $display("FAIL busy_start_len: got %0d want 1000", len);
    end
    for (int i = 0; i < NCH; i++) begin
      get_beat(1'b0, beat);
      exp_b = {1'b1, 4'(i), (i == 0) ? 32'd100 : 32'd0, 1'b0, (i == NCH - 1)};
      tests_run++;
      if (beat !== exp_b) begin
        tests_failed++; $display("FAIL busy_start_beat%0d: got %h want %h", i, beat, exp_b);
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL busy_start_no_rerun: got %b want 0", busy);
    end
  endtask

  task automatic test_missed();
    logic [38:0] beat, exp_b;
    halfp[1] = 10;
    bus.m_ready = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (missed !== 1'b0) begin
      tests_failed++; $display("FAIL missed_before: got %b want 0", missed);
    end
    continuous = 1'b1;
    repeat (1010) @(negedge clk);
    halfp[1] = 3;
    repeat (500) @(negedge clk);
    continuous = 1'b0;
    repeat (600) @(negedge clk);
    tests_run++;
    if ({missed, busy} !== 2'b10) begin
      tests_failed++; $display("FAIL missed_set: got missed,busy=%b want 10", {missed, busy});
    end
    beat = {bus.m_valid, bus.m_chan, bus.m_freq, bus.m_ovf, bus.m_last};
    tests_run++;
    if (beat !== {1'b1, 4'd0, 32'd100, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL missed_held_beat0: got %h want first-window ch0", beat);
    end
    bus.m_ready = 1'b1;
    for (int i = 1; i < NCH; i++) begin
      get_beat(1'b0, beat);
      exp_b = {1'b1, 4'(i), (i == 1) ? 32'd50 : 32'd0, 1'b0, (i == NCH - 1)};
      tests_run++;
      if (beat !== exp_b) begin
        tests_failed++; $display("FAIL missed_beat%0d: got %h want %h", i, beat, exp_b);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if ({bus.m_valid, missed} !== 2'b01) begin
      tests_failed++; $display("FAIL missed_after_drain: got valid,missed=%b want 01", {bus.m_valid, missed});
    end
    halfp[1] = 0;
  endtask

  task automatic test_reset_mid_window();
    logic [41:0] obs;
    bit bad;
    pulse_start(1'b0);
    repeat (399) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    obs = {busy, missed, bus.m_valid, bus.m_last, bus.m_chan, bus.m_freq, bus.m_ovf};
    tests_run++;
    if (obs !== 42'd0) begin
      tests_failed++; $display("FAIL midreset_outputs: got %h want 0", obs);
    end
    bad = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_no_beats: got activity=%b want 0", bad);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    continuous  = 1'b0;
    start2      = 1'b0;
    cont2       = 1'b0;
    gate_shift  = 3'd0;
    bus.m_ready  = 1'b1;
    bus2.m_ready = 1'b1;
    halfp[0] = 5;
    halfp[1] = 0;
    halfp[2] = 0;
    halfp[3] = 0;
    test_reset();
    test_single_window();
    test_gate_shift();
    test_overflow();
    test_start_while_busy();
    test_missed();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
